// File: rtl/qpu_timed_event_scheduler.sv
// Timed event scheduler: in-order FIFO of timestamped trigger events released against a local counter.
// Optional build macro QPU_SCHED_LATE_DROP_EN: late events are popped but not fired.
module qpu_timed_event_scheduler #(
  parameter int TIME_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int EVENT_NUM  = 8,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enq_i_valid,
  output logic                  enq_o_ready,
  input  logic [TIME_WIDTH-1:0] enq_i_time,
  input  logic [EVENT_NUM-1:0]  enq_i_mask,
  input  logic [DATA_WIDTH-1:0] enq_i_data,
  input  logic                  i_trigger,
  input  logic                  i_halt,
  input  logic                  i_flush,
  output logic [TIME_WIDTH-1:0] o_time,
  output logic                  o_clk_ena,
  output logic [EVENT_NUM-1:0]  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_late,
  output logic                  o_busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  state_t state;

  logic [TIME_WIDTH-1:0] cnt;
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;

  logic [TIME_WIDTH-1:0] mem_time [DEPTH];
  logic [EVENT_NUM-1:0]  mem_mask [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];

  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  late;
  logic [TIME_WIDTH-1:0] head_time;
  logic [EVENT_NUM-1:0]  head_mask;
  logic [DATA_WIDTH-1:0] head_data;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign head_time = mem_time[rd_ptr[AW-1:0]];
  assign head_mask = mem_mask[rd_ptr[AW-1:0]];
  assign head_data = mem_data[rd_ptr[AW-1:0]];

  // Head is tested against the counter value before this edge's increment.
  assign pop  = (state == RUN) && !i_halt && !i_flush &&
                !empty && (head_time <= cnt);
  assign late = (head_time < cnt);
  assign push = enq_i_valid && !full && !i_flush;

  assign enq_o_ready = !full;
  assign o_time      = cnt;
  assign o_clk_ena   = (state == RUN);
  assign o_busy      = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_time[wr_ptr[AW-1:0]] <= enq_i_time;
      mem_mask[wr_ptr[AW-1:0]] <= enq_i_mask;
      mem_data[wr_ptr[AW-1:0]] <= enq_i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_valid <= '0;
      o_data  <= '0;
      o_late  <= 1'b0;
    end else if (i_flush) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_valid <= '0;
      o_late  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

`ifdef QPU_SCHED_LATE_DROP_EN
      o_valid <= (pop && !late) ? head_mask : '0;
      if (pop && !late) o_data <= head_data;
`else
      o_valid <= pop ? head_mask : '0;
      if (pop) o_data <= head_data;
`endif
      o_late <= pop && late;

      if ((state == RUN) && !i_halt && (cnt != '1))
        cnt <= cnt + 1'b1;

      unique case (state)
        IDLE: if (!i_halt && i_trigger) state <= RUN;
        RUN:  if (i_halt) state <= HALT;
        HALT: if (!i_halt && i_trigger) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qpu_timed_event_scheduler.sv
// Bench for qpu_timed_event_scheduler: directed scenarios plus random traffic
// against a queue-based reference model of the scheduling rules.
module tb_qpu_timed_event_scheduler;

  localparam int TW   = 8;
  localparam int DW   = 16;
  localparam int EN   = 8;
  localparam int D    = 8;
  localparam int TMAX = (1 << TW) - 1;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_HALT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enq_i_valid;
  logic          enq_o_ready;
  logic [TW-1:0] enq_i_time;
  logic [EN-1:0] enq_i_mask;
  logic [DW-1:0] enq_i_data;
  logic          i_trigger;
  logic          i_halt;
  logic          i_flush;
  logic [TW-1:0] o_time;
  logic          o_clk_ena;
  logic [EN-1:0] o_valid;
  logic [DW-1:0] o_data;
  logic          o_late;
  logic          o_busy;

  qpu_timed_event_scheduler #(
    .TIME_WIDTH(TW),
    .DATA_WIDTH(DW),
    .EVENT_NUM (EN),
    .DEPTH     (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enq_i_valid(enq_i_valid),
    .enq_o_ready(enq_o_ready),
    .enq_i_time (enq_i_time),
    .enq_i_mask (enq_i_mask),
    .enq_i_data (enq_i_data),
    .i_trigger  (i_trigger),
    .i_halt     (i_halt),
    .i_flush    (i_flush),
    .o_time     (o_time),
    .o_clk_ena  (o_clk_ena),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_late     (o_late),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t;
    int mask;
    int data;
  } ev_t;

  ev_t q[$];
  int  m_state;
  int  m_time;
  int  m_valid;
  int  m_data;
  int  m_late;

  int n_cmp;
  int n_fail;

  task automatic model_reset();
    q.delete();
    m_state = S_IDLE;
    m_time  = 0;
    m_valid = 0;
    m_data  = 0;
    m_late  = 0;
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int  sz;
    bit  acc;
    bit  take;
    ev_t h;
    sz = q.size();
    if (i_flush) begin
      q.delete();
      m_time  = 0;
      m_state = S_IDLE;
      m_valid = 0;
      m_late  = 0;
      return;
    end
    acc  = enq_i_valid && (sz < D);
    take = (m_state == S_RUN) && !i_halt && (sz > 0);
    if (take) take = (q[0].t <= m_time);
    m_valid = 0;
    m_late  = 0;
    if (take) begin
      h = q.pop_front();
      m_late = (h.t < m_time) ? 1 : 0;
`ifdef QPU_SCHED_LATE_DROP_EN
      if (m_late == 0) begin
        m_valid = h.mask;
        m_data  = h.data;
      end
`else
      m_valid = h.mask;
      m_data  = h.data;
`endif
    end
    if (acc) begin
      h.t    = int'(enq_i_time);
      h.mask = int'(enq_i_mask);
      h.data = int'(enq_i_data);
      q.push_back(h);
    end
    if (m_state == S_RUN && !i_halt && m_time < TMAX) m_time++;
    if (i_halt) begin
      if (m_state == S_RUN) m_state = S_HALT;
    end else if (i_trigger) begin
      m_state = S_RUN;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enq_i_valid = 1'b0;
    enq_i_time  = '0;
    enq_i_mask  = '0;
    enq_i_data  = '0;
    i_trigger   = 1'b0;
    i_halt      = 1'b0;
    i_flush     = 1'b0;
  endtask

  task automatic do_flush();
    idle_inputs();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
  endtask

  task automatic enqueue(input int t, input int mask, input int data);
    enq_i_valid = 1'b1;
    enq_i_time  = TW'(t);
    enq_i_mask  = EN'(mask);
    enq_i_data  = DW'(data);
    tick();
    enq_i_valid = 1'b0;
  endtask

  task automatic trigger();
    i_trigger = 1'b1;
    tick();
    i_trigger = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (enq_o_ready !== 1'b1 || o_time !== '0 || o_clk_ena !== 1'b0 ||
        o_valid !== '0 || o_data !== '0 || o_late !== 1'b0 ||
        o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: rdy=%b time=%0d ena=%b valid=%h data=%h late=%b busy=%b, required rdy=1 others 0",
               enq_o_ready, o_time, o_clk_ena, o_valid, o_data, o_late, o_busy);
    end
  endtask

  task automatic test_basic();
    do_flush();
    enqueue(5, 8'h01, 16'h00A5);
    trigger();
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_cmp++;
      if (o_valid !== '0 || o_time !== TW'(k)) begin
        n_fail++;
        $display("FAIL basic_wait: valid=%h time=%0d, required valid=0 time=%0d",
                 o_valid, o_time, k);
      end
    end
    tick();
    n_cmp++;
    if (o_valid !== 8'h01 || o_data !== 16'h00A5 || o_late !== 1'b0 ||
        o_time !== 8'd6) begin
      n_fail++;
      $display("FAIL basic_fire: valid=%h data=%h late=%b time=%0d, required 01 00a5 0 6",
               o_valid, o_data, o_late, o_time);
    end
    tick();
    n_cmp++;
    if (o_valid !== '0 || o_data !== 16'h00A5) begin
      n_fail++;
      $display("FAIL basic_after: valid=%h data=%h, required valid=0 data=00a5",
               o_valid, o_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [EN-1:0] exp_v;
    do_flush();
    enqueue(3, 8'h02, 16'h0222);
    enqueue(3, 8'h04, 16'h0444);
    trigger();
    repeat (3) tick();
    tick();
    n_cmp++;
    if (o_valid !== 8'h02 || o_late !== 1'b0 || o_data !== 16'h0222) begin
      n_fail++;
      $display("FAIL b2b_first: valid=%h late=%b data=%h, required 02 0 0222",
               o_valid, o_late, o_data);
    end
    tick();
`ifdef QPU_SCHED_LATE_DROP_EN
    exp_v = 8'h00;
`else
    exp_v = 8'h04;
`endif
    n_cmp++;
    if (o_valid !== exp_v || o_late !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: valid=%h late=%b, required %h 1",
               o_valid, o_late, exp_v);
    end
    tick();
    n_cmp++;
    if (o_late !== 1'b0 || o_busy !== 1'b1 || o_clk_ena !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_tail: late=%b busy=%b ena=%b, required 0 1 1",
               o_late, o_busy, o_clk_ena);
    end
  endtask

  task automatic test_fill_stall();
    int acc;
    int fires[$];
    int guard;
    bit rdy;
    do_flush();
    acc = 0;
    for (int k = 0; k < D; k++) enqueue(20 + k, k + 1, 16'h0100 + k);
    n_cmp++;
    if (enq_o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: ready=%b, required 0", enq_o_ready);
    end
    enq_i_valid = 1'b1;
    enq_i_time  = TW'(20 + D);
    enq_i_mask  = EN'(D + 1);
    enq_i_data  = DW'(16'h0100 + D);
    i_trigger   = 1'b1;
    guard = 0;
    while (fires.size() < D + 1 && guard < 100) begin
      rdy = enq_o_ready;
      tick();
      i_trigger = 1'b0;
      if (rdy && enq_i_valid) begin
        acc = 1;
        enq_i_valid = 1'b0;
      end
      if (o_valid !== '0) fires.push_back(int'(o_valid));
      guard++;
    end
    n_cmp++;
    if (acc != 1 || fires.size() != D + 1) begin
      n_fail++;
      $display("FAIL fill_count: accepted9=%0d fires=%0d, required 1 %0d",
               acc, fires.size(), D + 1);
    end
    for (int k = 0; k < fires.size(); k++) begin
      n_cmp++;
      if (fires[k] != k + 1) begin
        n_fail++;
        $display("FAIL fill_order[%0d]: mask=%h, required %h", k, fires[k], k + 1);
      end
    end
  endtask

  task automatic test_halt_resume();
    do_flush();
    enqueue(10, 8'h08, 16'h0010);
    trigger();
    repeat (6) tick();
    i_halt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if (o_time !== 8'd6 || o_clk_ena !== 1'b0 || o_valid !== '0) begin
        n_fail++;
        $display("FAIL halt_hold: time=%0d ena=%b valid=%h, required 6 0 00",
                 o_time, o_clk_ena, o_valid);
      end
    end
    i_halt = 1'b0;
    trigger();
    n_cmp++;
    if (o_time !== 8'd6 || o_clk_ena !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_resume: time=%0d ena=%b, required 6 1", o_time, o_clk_ena);
    end
    repeat (4) tick();
    n_cmp++;
    if (o_time !== 8'd10 || o_valid !== '0) begin
      n_fail++;
      $display("FAIL halt_match: time=%0d valid=%h, required 10 00", o_time, o_valid);
    end
    tick();
    n_cmp++;
    if (o_valid !== 8'h08 || o_data !== 16'h0010 || o_late !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_fire: valid=%h data=%h late=%b, required 08 0010 0",
               o_valid, o_data, o_late);
    end
  endtask

  task automatic test_flush();
    int seen;
    do_flush();
    enqueue(5, 8'h10, 16'h0A01);
    enqueue(6, 8'h20, 16'h0A02);
    enqueue(7, 8'h40, 16'h0A03);
    trigger();
    repeat (2) tick();
    i_flush = 1'b1;
    enq_i_valid = 1'b1;
    enq_i_time  = 8'd9;
    enq_i_mask  = 8'h80;
    tick();
    i_flush = 1'b0;
    enq_i_valid = 1'b0;
    n_cmp++;
    if (o_busy !== 1'b0 || o_time !== '0 || o_valid !== '0 ||
        enq_o_ready !== 1'b1 || o_clk_ena !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_state: busy=%b time=%0d valid=%h rdy=%b ena=%b, required 0 0 00 1 0",
               o_busy, o_time, o_valid, enq_o_ready, o_clk_ena);
    end
    seen = 0;
    trigger();
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (o_valid !== '0) seen++;
    end
    n_cmp++;
    if (seen != 0 || o_time !== 8'd12) begin
      n_fail++;
      $display("FAIL flush_restart: fires=%0d time=%0d, required 0 12", seen, o_time);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    do_flush();
    enqueue(3, 8'h01, 16'h0BEE);
    trigger();
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (enq_o_ready !== 1'b1 || o_time !== '0 || o_clk_ena !== 1'b0 ||
        o_valid !== '0 || o_data !== '0 || o_late !== 1'b0 ||
        o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: rdy=%b time=%0d ena=%b valid=%h data=%h late=%b busy=%b, required 1 0 0 00 0000 0 0",
               enq_o_ready, o_time, o_clk_ena, o_valid, o_data, o_late, o_busy);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (o_valid !== '0) seen++;
    end
    n_cmp++;
    if (seen != 0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after: fires=%0d busy=%b, required 0 0", seen, o_busy);
    end
  endtask

  task automatic test_saturate();
    do_flush();
    enqueue(250, 8'h80, 16'h0055);
    trigger();
    repeat (270) tick();
    n_cmp++;
    if (o_time !== 8'hFF || m_data != 16'h0055 || o_data !== 16'h0055) begin
      n_fail++;
      $display("FAIL sat_time: time=%0d data=%h, required 255 0055", o_time, o_data);
    end
    enqueue(255, 8'h40, 16'h0066);
    tick();
    n_cmp++;
    if (o_valid !== 8'h40 || o_late !== 1'b0 || o_time !== 8'hFF) begin
      n_fail++;
      $display("FAIL sat_fire: valid=%h late=%b time=%0d, required 40 0 255",
               o_valid, o_late, o_time);
    end
  endtask

  task automatic test_random();
    int t;
    for (int c = 0; c < 2000; c++) begin
      enq_i_valid = ($urandom % 3) == 0;
      t = m_time + int'($urandom_range(0, 12)) - 2;
      if (t < 0) t = 0;
      if (t > TMAX) t = TMAX;
      enq_i_time = TW'(t);
      enq_i_mask = EN'($urandom);
      enq_i_data = DW'($urandom);
      i_trigger  = ($urandom % 5) == 0;
      i_halt     = ($urandom % 17) == 0;
      i_flush    = ($urandom % 200) == 0;
      tick();
      n_cmp++;
      if (o_valid !== EN'(m_valid) || o_data !== DW'(m_data) ||
          o_late !== m_late[0] || o_time !== TW'(m_time) ||
          o_clk_ena !== (m_state == S_RUN) ||
          enq_o_ready !== (q.size() < D) ||
          o_busy !== (m_state != S_IDLE || q.size() > 0)) begin
        n_fail++;
        $display("FAIL random[%0d]: valid=%h/%h data=%h/%h late=%b/%0d time=%0d/%0d ena=%b rdy=%b busy=%b (state=%0d qsz=%0d)",
                 c, o_valid, m_valid, o_data, m_data, o_late, m_late,
                 o_time, m_time, o_clk_ena, enq_o_ready, o_busy,
                 m_state, q.size());
      end
    end
    idle_inputs();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_basic();
    test_back_to_back();
    test_fill_stall();
    test_halt_resume();
    test_flush();
    test_reset_mid_run();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/qpu_timed_event_scheduler.md
# qpu_timed_event_scheduler

- Timed event scheduler between the QPU execute stage and the trigger outputs.
- Buffers timestamped events (channel mask + payload) in an in-order FIFO.
- Runs a local time counter once triggered, and releases each event on the trigger outputs when the counter reaches its timestamp.
- Gives the core an issue-ahead queue, so quantum operation timing is decoupled from instruction execution timing.

## Interface
Parameters:
- TIME_WIDTH, 32, width of timestamps and time counter
- DATA_WIDTH, 32, event payload width
- EVENT_NUM, 8, number of trigger channels (mask width)
- DEPTH, 8, FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- enq_i_valid  in  1  event enqueue request
- enq_o_ready  out  1  FIFO can accept; equals !full, registered-state derived, no path from enq_i_valid
- enq_i_time  in  TIME_WIDTH  absolute release time
- enq_i_mask  in  EVENT_NUM  channels to fire
- enq_i_data  in  DATA_WIDTH  payload
- i_trigger  in  1  start/resume counting
- i_halt  in  1  freeze counter and issue
- i_flush  in  1  discard queue, zero counter, return to IDLE
- o_time  out  TIME_WIDTH  current counter value
- o_clk_ena  out  1  high while in RUN
- o_valid  out  EVENT_NUM  one-cycle fire mask
- o_data  out  DATA_WIDTH  payload of fired event; holds last value otherwise
- o_late  out  1  one-cycle late-event pulse
- o_busy  out  1  state != IDLE or FIFO non-empty

## Operation
States:
- IDLE: counter held at 0.
  - i_trigger → RUN.
- RUN: counter +1 per cycle, saturating at all-ones.
  - i_halt → HALT.
- HALT: counter frozen, no issue.
  - i_trigger → RUN.

Priority, highest first:
- i_flush (any state): empty FIFO, counter=0, go to IDLE; enqueue in the same cycle is dropped.
- i_halt.
- i_trigger.

Issue rule:
- In RUN, with FIFO non-empty and head.time ≤ o_time at the clock edge: pop the head and register o_valid<=head.mask, o_data<=head.data.
- Otherwise o_valid<=0.
- At most one event per cycle. Events sharing a timestamp must be merged into one mask by software.
- Comparison is unsigned. There is no wrap-around: once saturated, every remaining event is eligible.

Late event:
- head.time < o_time at issue.
- Normal when the previous pop delayed it, or when it was enqueued with a past time.

Ordering and enqueue:
- Enqueue order must have nondecreasing timestamps. This is not checked; the queue is strictly FIFO.
- Enqueue and pop in the same cycle are legal at any occupancy, except that enqueue when full is ignored (ready low).
- An enqueued entry becomes head-eligible the cycle after its write.

Reset values:
- state=IDLE, counter=0, FIFO empty.
- enq_o_ready=1; all other outputs 0.

## Timing
Issue timing:
- Counter value T is visible on o_time during cycle T after RUN entry.
- Event with time T (enqueued early) has o_valid high in the cycle after o_time==T, so issue latency is 1 cycle from match.
- Entering RUN: i_trigger sampled at edge e0 gives o_time=0 after e0, 1 after e1, and so on.

Halt and resume:
- i_halt takes effect at the same edge: counter does not increment, and no pop at that edge.
- Resume continues from the frozen value.

Other timing:
- o_late is coincident with the corresponding o_valid (or with the dropped slot, see Configuration).
- enq_o_ready updates one cycle after the push/pop that changed occupancy.
- An asynchronous reset mid-operation aborts immediately. No partial event is emitted after rst_n deasserts.

## Configuration
QPU_SCHED_LATE_DROP_EN:
- Defined: late events are popped but not fired. o_valid stays 0 for that slot, and o_late pulses for one cycle.
- Undefined: late events fire normally with o_late high alongside o_valid.
- Non-late events behave identically in both builds.

## Test plan
- Basic release: enqueue (time=5, mask=0x01, data=0xA5), then trigger → o_valid=0x01, o_data=0xA5 in the cycle after o_time==5; o_late=0.
- Back-to-back same time: enqueue t=3 mask 0x02, then t=3 mask 0x04 → 0x02 after o_time==3, 0x04 next cycle with o_late=1 (drop build: o_valid=0, o_late=1).
- Fill and stall: enqueue 9 events with DEPTH=8 → enq_o_ready=0 after 8; the 9th is held until the first pop, then accepted; order preserved.
- Halt/resume: event t=10, halt at o_time==6 for 4 cycles → o_time stays 6, o_clk_ena=0; after resume, fires after o_time==10.
- Flush mid-run: 3 queued, flush at o_time==2 → o_busy=0, o_time=0, no o_valid ever; next trigger restarts from 0.
- Reset mid-run: assert rst_n=0 while an event is due → all outputs 0 and enq_o_ready=1 immediately; no event after release.
